// File: rtl/macro_extract_if.sv
// Bus bundle between macro_extract, the distribution BRAM read port, the display buffer and the sequencer.
// The slave modport is the macro_extract side; master is the environment side.
interface macro_extract_if #(
  parameter int HPIXELS = 205,
  parameter int VPIXELS = 154,
  parameter int DW      = 9
) ();
  localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS);

  logic                 start_in;
  logic [8:0][DW-1:0]   data_in;
  logic [BRAM_SIZE-1:0] rd_addr_out;
  logic [BRAM_SIZE-1:0] wr_addr_out;
  logic [7:0]           speed_out;
  logic [7:0]           density_out;
  logic                 wr_en_out;
  logic                 busy_out;
  logic                 done;

  modport slave (
    input  start_in, data_in,
    output rd_addr_out, wr_addr_out, speed_out, density_out, wr_en_out, busy_out, done
  );

  modport master (
    output start_in, data_in,
    input  rd_addr_out, wr_addr_out, speed_out, density_out, wr_en_out, busy_out, done
  );
endinterface

// File: rtl/macro_extract.sv
// Raster walk over the lattice: per cell READ(3)/SUM(1)/DIV(N)/WRITE(1), producing speed and density pixels.
// Fixed N+5 cycle period per cell, no backpressure; done pulses one cycle after the last write.
module macro_extract #(
  parameter int HPIXELS   = 205,
  parameter int VPIXELS   = 154,
  parameter int DW        = 9,
  parameter int FRAC      = 8,
  parameter int RHO_SHIFT = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  macro_extract_if.slave bus
);
  localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS);
  localparam int N   = DW + 3 + FRAC;
  localparam int RW  = DW + 4;
  localparam int PW  = DW + 2;
  localparam int CW  = $clog2(N);
  localparam int HW  = (HPIXELS > 1) ? $clog2(HPIXELS) : 1;
  localparam int VW  = (VPIXELS > 1) ? $clog2(VPIXELS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_SUM    = 3'd2;
  localparam logic [2:0] S_DIV    = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [HW-1:0]        hor;
  logic [VW-1:0]        vert;
  logic [8:0][DW-1:0]   f_q;
  logic [RW-1:0]        rho;
  logic [N-1:0]         num_sh;
  logic [RW-1:0]        rem;
  logic [N-1:0]         quo;
  logic [BRAM_SIZE-1:0] rd_addr_q;
  logic [BRAM_SIZE-1:0] wr_addr_q;
  logic [7:0]           speed_q;
  logic [7:0]           density_q;

  logic [RW-1:0] rho_c;
  logic [PW-1:0] pos_x, neg_x, pos_y, neg_y, abs_x, abs_y;
  logic [DW+2:0] mag;
  logic [N-1:0]  num_c;

  always_comb begin
    rho_c = '0;
    for (int i = 0; i < 9; i++) rho_c = rho_c + RW'(f_q[i]);
    pos_x = PW'(f_q[1]) + PW'(f_q[5]) + PW'(f_q[8]);
    neg_x = PW'(f_q[3]) + PW'(f_q[6]) + PW'(f_q[7]);
    pos_y = PW'(f_q[2]) + PW'(f_q[5]) + PW'(f_q[6]);
    neg_y = PW'(f_q[4]) + PW'(f_q[7]) + PW'(f_q[8]);
    // |mx| and |my| taken directly from the two partial sums, avoiding a signed negate
    abs_x = (pos_x >= neg_x) ? (pos_x - neg_x) : (neg_x - pos_x);
    abs_y = (pos_y >= neg_y) ? (pos_y - neg_y) : (neg_y - pos_y);
    mag   = (DW+3)'(abs_x) + (DW+3)'(abs_y);
    num_c = {mag, {FRAC{1'b0}}};
  end

  logic [RW:0]   rem_sh;
  logic          ge;
  logic [RW:0]   rem_nx;
  logic [N-1:0]  quo_nx;
  logic [RW-1:0] rho_px;
  logic [7:0]    speed_c;
  logic [7:0]    density_c;

  always_comb begin
    rem_sh    = {rem, num_sh[N-1]};
    ge        = (rem_sh >= {1'b0, rho});
    rem_nx    = ge ? (rem_sh - {1'b0, rho}) : rem_sh;
    quo_nx    = {quo[N-2:0], ge};
    rho_px    = rho >> RHO_SHIFT;
    // divide by zero yields all-ones quotient, so zero density forces speed 0
    if (rho == '0)
      speed_c = 8'd0;
    else if (quo_nx > N'(255))
      speed_c = 8'hFF;
    else
      speed_c = quo_nx[7:0];
    density_c = (rho_px > RW'(255)) ? 8'hFF : rho_px[7:0];
  end

  wire last_cell = (hor == HW'(HPIXELS - 1)) && (vert == VW'(VPIXELS - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hor       <= '0;
      vert      <= '0;
      f_q       <= '0;
      rho       <= '0;
      num_sh    <= '0;
      rem       <= '0;
      quo       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      speed_q   <= '0;
      density_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_in) begin
            hor       <= '0;
            vert      <= '0;
            rd_addr_q <= '0;
            cnt       <= '0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (cnt == CW'(2)) begin
            f_q   <= bus.data_in;
            cnt   <= '0;
            state <= S_SUM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SUM: begin
          rho    <= rho_c;
          num_sh <= num_c;
          rem    <= '0;
          quo    <= '0;
          cnt    <= '0;
          state  <= S_DIV;
        end
        S_DIV: begin
          rem    <= rem_nx[RW-1:0];
          quo    <= quo_nx;
          num_sh <= {num_sh[N-2:0], 1'b0};
          if (cnt == CW'(N - 1)) begin
            speed_q   <= speed_c;
            density_q <= density_c;
            wr_addr_q <= rd_addr_q;
            cnt       <= '0;
            state     <= S_WRITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (last_cell) begin
            state <= S_FINISH;
          end else begin
            if (hor == HW'(HPIXELS - 1)) begin
              hor  <= '0;
              vert <= vert + 1'b1;
            end else begin
              hor <= hor + 1'b1;
            end
            rd_addr_q <= rd_addr_q + 1'b1;
            state     <= S_READ;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_addr_out = rd_addr_q;
  assign bus.wr_addr_out = wr_addr_q;
  assign bus.speed_out   = speed_q;
  assign bus.density_out = density_q;
  assign bus.wr_en_out   = (state == S_WRITE);
  assign bus.busy_out    = (state == S_READ) || (state == S_SUM) || (state == S_DIV) || (state == S_WRITE);
  assign bus.done        = (state == S_FINISH);
endmodule

// File: tb/tb_macro_extract.sv
// Small-lattice bench: 2-cycle BRAM model, randomized cell contents, per-cycle checks against an arithmetic model.
module tb_macro_extract;
  localparam int H      = 4;
  localparam int V      = 3;
  localparam int CELLS  = H * V;
  localparam int N      = 9 + 3 + 8;
  localparam int PERIOD = N + 5;
  localparam int TOTAL  = PERIOD * CELLS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  macro_extract_if #(.HPIXELS(H), .VPIXELS(V), .DW(9)) bus ();

  macro_extract #(.HPIXELS(H), .VPIXELS(V), .DW(9), .FRAC(8), .RHO_SHIFT(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  logic [8:0][8:0] mem [CELLS];
  logic [8:0][8:0] d1;
  always @(posedge clk) begin
    d1          <= mem[bus.rd_addr_out];
    bus.data_in <= d1;
  end

  int exp_sp [CELLS];
  int exp_dn [CELLS];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic void model(input logic [8:0][8:0] f, output int sp, output int dn);
    int rho, mx, my, a;
    rho = 0;
    for (int i = 0; i < 9; i++) rho += int'(f[i]);
    mx = int'(f[1]) + int'(f[5]) + int'(f[8]) - int'(f[3]) - int'(f[6]) - int'(f[7]);
    my = int'(f[2]) + int'(f[5]) + int'(f[6]) - int'(f[4]) - int'(f[7]) - int'(f[8]);
    a  = (mx < 0 ? -mx : mx) + (my < 0 ? -my : my);
    sp = (rho == 0) ? 0 : (a * 256) / rho;
    if (sp > 255) sp = 255;
    dn = rho / 16;
    if (dn > 255) dn = 255;
  endfunction

  task automatic fill_random(input int first);
    for (int c = first; c < CELLS; c++) begin
      int lim;
      lim = ($urandom_range(0, 1) == 0) ? 511 : 40;
      for (int i = 0; i < 9; i++) mem[c][i] = 9'($urandom_range(0, lim));
      if ($urandom_range(0, 3) == 0) mem[c][0] = 9'd511;
      model(mem[c], exp_sp[c], exp_dn[c]);
    end
  endtask

  task automatic set_cell(input int c, input int v0, input int i1, input int v1, input int sp, input int dn);
    for (int i = 0; i < 9; i++) mem[c][i] = 9'd0;
    mem[c][0]  = 9'(v0);
    mem[c][i1] = 9'(v1);
    exp_sp[c]  = sp;
    exp_dn[c]  = dn;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr_out), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr_out), 0);
    chk({tag, "_speed"},   32'(bus.speed_out),   0);
    chk({tag, "_density"}, 32'(bus.density_out), 0);
    chk({tag, "_wr_en"},   32'(bus.wr_en_out),   0);
    chk({tag, "_busy"},    32'(bus.busy_out),    0);
    chk({tag, "_done"},    32'(bus.done),        0);
  endtask

  // rst_at < 0: full pass; otherwise reset is sampled at the end of relative cycle rst_at
  task automatic run_pass(input int rst_at);
    int  rel, k, limit;
    bit  aborted, exp_wr;
    k       = 0;
    aborted = 1'b0;
    limit   = (rst_at >= 0) ? rst_at + 30 : TOTAL + 4;
    @(negedge clk);
    bus.start_in = 1'b1;
    @(negedge clk);
    rel = 1;
    while (rel <= limit) begin
      if (rst_at >= 0 && rel == rst_at + 1) begin
        rst = 1'b0;
        chk_reset_vals("abort");
      end
      exp_wr = !aborted && (k < CELLS) && (rel == PERIOD * (k + 1));
      chk("wr_en", 32'(bus.wr_en_out), 32'(exp_wr));
      if (exp_wr && bus.wr_en_out) begin
        chk("wr_addr", 32'(bus.wr_addr_out), 32'(k));
        chk("speed",   32'(bus.speed_out),   32'(exp_sp[k]));
        chk("density", 32'(bus.density_out), 32'(exp_dn[k]));
        k++;
      end else if (!aborted && k > 0) begin
        chk("speed_hold",   32'(bus.speed_out),   32'(exp_sp[k-1]));
        chk("density_hold", 32'(bus.density_out), 32'(exp_dn[k-1]));
      end
      chk("busy", 32'(bus.busy_out), 32'(!aborted && rel >= 1 && rel <= TOTAL));
      chk("done", 32'(bus.done),     32'(!aborted && rel == TOTAL + 1));
      if (rst_at >= 0 && rel == rst_at) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end
      // random start pulses through the pass, including the FINISH cycle, must be ignored
      bus.start_in = (!aborted && rel <= TOTAL + 1) ? ($urandom_range(0, 4) == 0) : 1'b0;
      @(negedge clk);
      rel++;
    end
    bus.start_in = 1'b0;
    if (rst_at < 0) chk("n_writes", 32'(k), 32'(CELLS));
  endtask

  initial begin
    rst          = 1'b1;
    bus.start_in = 1'b0;
    for (int c = 0; c < CELLS; c++) mem[c] = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) mem[0][i] = 9'd10;
    exp_sp[0] = 0;
    exp_dn[0] = 5;
    set_cell(1, 0, 1, 100, 255, 6);
    set_cell(2, 60, 1, 20, 64, 5);
    set_cell(3, 90, 5, 30, 128, 7);
    set_cell(4, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) mem[5][i] = 9'd511;
    exp_sp[5] = 0;
    exp_dn[5] = 255;
    fill_random(6);
    run_pass(-1);

    fill_random(0);
    run_pass(60);
    run_pass(-1);

    fill_random(0);
    run_pass(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
